// File: rtl/vga_pkg.sv
// Shared types and mode presets for the raster timing generator.
// Optional frame counter is enabled with VGA_FRAME_CNT_EN.
package vga_pkg;

  typedef struct packed {
    int   active;
    int   fp;
    int   sync;
    int   bp;
    logic pol;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_mode_t;

  localparam vga_mode_t VGA_640X480_60 = '{
    h: '{active: 640, fp: 16, sync: 96, bp: 48, pol: 1'b0},
    v: '{active: 480, fp: 10, sync: 2,  bp: 33, pol: 1'b0}
  };

  localparam vga_mode_t VGA_TINY = '{
    h: '{active: 4, fp: 1, sync: 2, bp: 1, pol: 1'b0},
    v: '{active: 3, fp: 1, sync: 1, bp: 1, pol: 1'b0}
  };

  function automatic int axis_total(vga_axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered
// position/sync decode of the pre-increment count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter vga_axis_t CFG = VGA_640X480_60.h,
  parameter int        W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cnt_en,
  input  logic         load_en,
  output logic         wrap,
  output logic         act,
  output logic [W-1:0] pos,
  output logic         sync
);

  localparam int TOTAL = axis_total(CFG);
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(CFG.active);
  localparam logic [W-1:0] SYNC_LO = W'(CFG.active + CFG.fp);
  localparam logic [W-1:0] SYNC_HI =
    W'(CFG.active + CFG.fp + CFG.sync - 1);

  logic [W-1:0] cnt;
  logic         in_sync;

  assign wrap    = (cnt == LAST);
  assign act     = (cnt < ACT_END);
  assign in_sync = (cnt >= SYNC_LO) && (cnt <= SYNC_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      pos  <= '0;
      sync <= ~CFG.pol;
    end else begin
      if (cnt_en)
        cnt <= wrap ? '0 : cnt + 1'b1;
      // outputs trail the counter by one enabled edge
      if (load_en) begin
        pos  <= cnt;
        sync <= in_sync ? CFG.pol : ~CFG.pol;
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable.
// Define VGA_FRAME_CNT_EN to add the frame_cnt output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_640X480_60.h.active,
  parameter int H_FP       = VGA_640X480_60.h.fp,
  parameter int H_SYNC     = VGA_640X480_60.h.sync,
  parameter int H_BP       = VGA_640X480_60.h.bp,
  parameter int V_ACTIVE   = VGA_640X480_60.v.active,
  parameter int V_FP       = VGA_640X480_60.v.fp,
  parameter int V_SYNC     = VGA_640X480_60.v.sync,
  parameter int V_BP       = VGA_640X480_60.v.bp,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int FRAME_W    = 8,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W     = $clog2(H_TOTAL),
  localparam int V_W     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           line_start,
`ifdef VGA_FRAME_CNT_EN
  output logic           frame_start,
  output logic [FRAME_W-1:0] frame_cnt
`else
  output logic           frame_start
`endif
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      FRAME_W < 1) begin : g_bad_cfg
    $error("vga_timing_gen: porch/sync/active must be >= 1");
  end

  localparam vga_axis_t H_CFG = '{
    active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP,
    pol: H_SYNC_POL
  };
  localparam vga_axis_t V_CFG = '{
    active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP,
    pol: V_SYNC_POL
  };

  logic h_wrap, h_act;
  logic v_wrap, v_act;
  logic line_pend, frame_pend;

  vga_axis_counter #(.CFG(H_CFG), .W(H_W)) u_h (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (ce),
    .load_en (ce),
    .wrap    (h_wrap),
    .act     (h_act),
    .pos     (x),
    .sync    (hsync)
  );

  vga_axis_counter #(.CFG(V_CFG), .W(V_W)) u_v (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (ce && h_wrap),
    .load_en (ce),
    .wrap    (v_wrap),
    .act     (v_act),
    .pos     (y),
    .sync    (vsync)
  );

  // *_pend marks that the counters currently sit at a line/frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_pend   <= 1'b1;
      frame_pend  <= 1'b1;
    end else if (ce) begin
      de          <= h_act && v_act;
      line_start  <= line_pend;
      frame_start <= frame_pend;
      line_pend   <= h_wrap;
      frame_pend  <= h_wrap && v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic first_q;

  // the frame entered right after reset keeps count 0
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      first_q   <= 1'b1;
    end else if (ce) begin
      first_q <= 1'b0;
      if (frame_pend && !first_q)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule
